// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor for unsigned and two's-complement
// operands. It processes BITS_PER_CYCLE bits per clock through a ripple slice
// of full-adder cells, carrying the running carry between cycles.
//
// Parameters:
//   WIDTH           operand/result width (>= 2)
//   BITS_PER_CYCLE  bits per RUN cycle (1..WIDTH, divides WIDTH)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start_valid  request to start an operation
//   start_ready  block idle and able to accept (state == IDLE)
//   a, b         operands, sampled at the accept edge
//   cin          carry-in (add) / borrow-in (sub), sampled at the accept edge
//   sub          0: a+b+cin, 1: a-b-cin, sampled at the accept edge
//   sum          registered result
//   cout         final carry out (subtract: 1 = no borrow)
//   ovf          signed overflow
//   done         one-cycle pulse, result valid and new
//   busy         high in RUN and DONE
module serial_addsub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done,
    output logic             busy
);

    // Guard against divide-by-zero while elaborating an illegal parameter set,
    // so the $error below is the message that gets reported.
    localparam int BPC_SAFE = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
    localparam int N        = WIDTH / BPC_SAFE;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
        (WIDTH % BPC_SAFE) != 0) begin : g_bad_params
        $error("serial_addsub: illegal WIDTH=%0d / BITS_PER_CYCLE=%0d",
               WIDTH, BITS_PER_CYCLE);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [WIDTH-1:0]          sa_q;
    logic [WIDTH-1:0]          sb_q;
    logic [WIDTH-1:0]          res_q;
    logic [WIDTH-1:0]          sum_q;
    logic                      carry_q;
    logic                      cout_q;
    logic                      ovf_q;
    logic                      done_q;
    logic                      busy_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic                      c_into_msb;
    logic                      c_out;
    logic [WIDTH+BITS_PER_CYCLE-1:0] res_cat;
    logic [WIDTH-1:0]          res_d;

    // Ripple slice over the low BITS_PER_CYCLE bits of the operand shift
    // registers. c_into_msb is the carry entering the top cell of the slice;
    // on the final slice that cell is the operand MSB, which is what the
    // signed overflow test needs.
    always_comb begin : ripple
        logic c;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        c          = carry_q;
        slice_sum  = '0;
        c_into_msb = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            c_into_msb   = c;
            slice_sum[i] = sa_q[i] ^ sb_q[i] ^ c;
            c            = (sa_q[i] & sb_q[i]) | (c & (sa_q[i] ^ sb_q[i]));
        end
        c_out = c;
    end

    // New slice bits enter at the top of the result register; after N cycles
    // the first slice has reached bit 0. The concatenation form also covers
    // BITS_PER_CYCLE == WIDTH, where no old result bits survive.
    assign res_cat = {slice_sum, res_q};
    assign res_d   = res_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        // Subtraction is A + ~B + 1; a borrow-in removes the +1.
                        sa_q    <= a;
                        sb_q    <= sub ? ~b : b;
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q    <= sa_q >> BITS_PER_CYCLE;
                    sb_q    <= sb_q >> BITS_PER_CYCLE;
                    res_q   <= res_d;
                    carry_q <= c_out;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= c_out;
                        ovf_q   <= c_into_msb ^ c_out;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor for unsigned and two's-complement operands. It processes BITS_PER_CYCLE bits per clock through an internal ripple slice of full-adder cells, carrying the running carry between cycles.
- Serves datapaths that trade latency for area versus a full-width combinational adder.
- Adds a start/ready handshake, subtract mode, signed overflow detection and a done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- BITS_PER_CYCLE, 1, bits processed per RUN cycle; must be 1..WIDTH and divide WIDTH exactly; any other value is an elaboration error ($error).
- Derived: N = WIDTH/BITS_PER_CYCLE (number of RUN cycles).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  request to start an operation.
- start_ready  output  1  block idle and able to accept; equals (state==IDLE).
- a  input  WIDTH  operand A; sampled only at the accept edge.
- b  input  WIDTH  operand B; sampled only at the accept edge.
- cin  input  1  carry-in (add) / borrow-in (sub); sampled at the accept edge.
- sub  input  1  0: A+B+cin; 1: A-B-cin; sampled at the accept edge.
- sum  output  WIDTH  result, registered.
- cout  output  1  final carry out; in subtract mode 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- done  output  1  one-cycle pulse; result valid and new.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset state: state=IDLE; sum=0, cout=0, ovf=0, done=0, busy=0. start_ready=1 from the first cycle after the reset edge.
- Reset mid-operation (RUN or DONE): aborts with no done pulse; all outputs take their reset values; the operation is lost.
- States: IDLE, RUN, DONE.
- Accept: at a rising edge where state==IDLE and start_valid==1.
  - Latch A into shift register SA.
  - Latch (sub ? ~B : B) into SB.
  - Set carry = cin ^ sub.
  - Clear cycle count; go to RUN.
- RUN, per cycle:
  - Add the low BITS_PER_CYCLE bits of SA and SB plus carry through a ripple chain.
  - Shift SA and SB right by BITS_PER_CYCLE.
  - Shift the slice result into the top of the result register.
  - Update carry; record the carry into the MSB cell on the final slice.
  - After N RUN cycles go to DONE, registering sum, cout and ovf.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE. done is never high in any other state.
- Latency: accept at edge E; done is high for the cycle following edge E+N; start_ready returns at edge E+N+1. Earliest next accept is E+N+2.
- Output hold: sum, cout and ovf hold their values from DONE until the next DONE or reset. They do not change during a later RUN.
- start_valid outside IDLE is ignored; operand inputs are not captured. No queueing.
- Subtract semantics: sum = (A - B - cin) mod 2^WIDTH.
  - cout = 1 iff A >= B + cin (unsigned).
  - ovf uses the signed interpretation.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, BPC=1: A=8'h35, B=8'h4A, cin=0, sub=0 -> sum=8'h7F, cout=0, ovf=0; done exactly 8 cycles after the accept edge, single-cycle pulse.
- Add boundaries:
  - 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
  - 8'hFF+8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0.
- Subtract:
  - 8'h10-8'h20, cin=0 -> sum=8'hF0, cout=0, ovf=0.
  - 8'h80-8'h01 -> sum=8'h7F, cout=1, ovf=1.
  - 8'h05-8'h05, cin=1 -> sum=8'hFF, cout=0.
- Handshake:
  - Hold start_valid=1 with changing a/b during RUN -> only the accept-edge operands are used; start_ready=0 throughout busy.
  - Back-to-back ops accept at E and E+10 -> both results correct; sum holds between them.
- Reset mid-operation: assert rst for one cycle at RUN cycle 3 -> next cycle state IDLE, outputs 0, no done pulse. A subsequent 8'h01+8'h02 gives 8'h03.
- Parameter sweep at WIDTH=8:
  - BPC=4 -> done 2 cycles after accept.
  - BPC=8 -> done 1 cycle after accept.
  - For both, 1000 random add/sub vectors match the reference model for sum, cout and ovf.
